// File: rtl/wimax_pkg.sv
// rtl/wimax_pkg.sv - WiMAX deinterleaver constants and inverse block permutation
package wimax_pkg;
  localparam int NCBPS = 192;
  localparam int NCPC  = 2;
  localparam int S     = NCPC / 2;
  localparam int D     = 16;
  localparam int IDX_W = $clog2(NCBPS);

  // Channel-order position j -> original coded position k; int intermediates hold d*Ncbps.
  function automatic logic [IDX_W-1:0] deint_index(input logic [IDX_W-1:0] j);
    int jj;
    int m;
    int dm;
    int k;
    jj = int'(j);
    m  = S * (jj / S) + ((jj + (D * jj) / NCBPS) % S);
    dm = D * m;
    k  = dm - (NCBPS - 1) * (dm / NCBPS);
    return IDX_W'(k);
  endfunction
endpackage

// File: rtl/deinterleaver_addr_gen.sv
// rtl/deinterleaver_addr_gen.sv - write counter j and its de-permuted buffer address k
module deinterleaver_addr_gen
  import wimax_pkg::*;
(
  input  logic             clk,
  input  logic             resetN,
  input  logic             advance,
  output logic [IDX_W-1:0] k,
  output logic             last_bit
);

  logic [IDX_W-1:0] j;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      j <= '0;
    end else if (advance) begin
      j <= last_bit ? '0 : j + 1'b1;
    end
  end

  assign last_bit = (j == IDX_W'(NCBPS - 1));
  assign k        = deint_index(j);

endmodule

// File: rtl/deinterleaver.sv
// rtl/deinterleaver.sv - WiMAX receive block deinterleaver, one bit in / one bit out per cycle
// DEINT_PINGPONG_EN selects two ping-pong banks; otherwise one bank alternates fill and drain.
module deinterleaver
  import wimax_pkg::*;
(
  input  logic             clk,
  input  logic             resetN,
  input  logic             data_in,
  input  logic             valid_demod,
  output logic             ready_deinterleaver,
  input  logic             ready_fec,
  output logic             data_out,
  output logic [IDX_W-1:0] data_out_index,
  output logic             valid_deinterleaver
);

  logic [NCBPS-1:0] bank_mem [2];
  logic [1:0]       full;
  logic             wr_bank;
  logic             rd_bank;
  logic [IDX_W-1:0] wr_k;
  logic [IDX_W-1:0] rd_cnt;
  logic             last_bit;
  logic             rd_last;
  logic             wr_fire;
  logic             rd_fire;

  // Ready and valid come only from registered flags, so there is no ready-to-ready path.
  assign ready_deinterleaver = !full[wr_bank];
  assign valid_deinterleaver = full[rd_bank];
  assign wr_fire             = valid_demod && ready_deinterleaver;
  assign rd_fire             = valid_deinterleaver && ready_fec;
  assign rd_last             = (rd_cnt == IDX_W'(NCBPS - 1));

  deinterleaver_addr_gen u_addr_gen (
    .clk      (clk),
    .resetN   (resetN),
    .advance  (wr_fire),
    .k        (wr_k),
    .last_bit (last_bit)
  );

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      bank_mem[wr_bank][wr_k] <= data_in;
    end
  end

  // Buffer contents are not reset, so the output is forced low until a block is ready.
  assign data_out       = valid_deinterleaver ? bank_mem[rd_bank][rd_cnt] : 1'b0;
  assign data_out_index = rd_cnt;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      full   <= '0;
      rd_cnt <= '0;
    end else begin
      if (wr_fire && last_bit) begin
        full[wr_bank] <= 1'b1;
      end
      if (rd_fire && rd_last) begin
        full[rd_bank] <= 1'b0;
      end
      if (rd_fire) begin
        rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
      end
    end
  end

`ifdef DEINT_PINGPONG_EN
  always_ff @(posedge clk) begin
    if (!resetN) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      if (wr_fire && last_bit) begin
        wr_bank <= !wr_bank;
      end
      if (rd_fire && rd_last) begin
        rd_bank <= !rd_bank;
      end
    end
  end
`else
  // Single bank: write and read share bank 0, the second bank and flag are never reached.
  assign wr_bank = 1'b0;
  assign rd_bank = 1'b0;
`endif

endmodule

// File: tb/tb_deinterleaver.sv
// tb/tb_deinterleaver.sv - self-checking bench for deinterleaver (either DEINT_PINGPONG_EN build)
module tb_deinterleaver;
  import wimax_pkg::*;

  logic             clk = 1'b0;
  logic             resetN;
  logic             data_in;
  logic             valid_demod;
  logic             ready_deinterleaver;
  logic             ready_fec;
  logic             data_out;
  logic [IDX_W-1:0] data_out_index;
  logic             valid_deinterleaver;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  deinterleaver dut (
    .clk                 (clk),
    .resetN              (resetN),
    .data_in             (data_in),
    .valid_demod         (valid_demod),
    .ready_deinterleaver (ready_deinterleaver),
    .ready_fec           (ready_fec),
    .data_out            (data_out),
    .data_out_index      (data_out_index),
    .valid_deinterleaver (valid_deinterleaver)
  );

  typedef struct {
    int j;
    int k;
  } vec_t;

  bit in_q[$];
  bit exp_q[$];
  bit out_d[$];
  int out_i[$];
  int out_cyc[$];
  int first_wr_cyc;
  int acc_cnt;
  int rdy_low_cnt;
  int unstable_cnt;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Forward transmit interleaver: original position k goes to channel position j.
  function automatic int fwd(input int k);
    int m;
    m = (NCBPS / D) * (k % D) + k / D;
    return S * (m / S) + ((m + NCBPS - (D * m) / NCBPS) % S);
  endfunction

  task automatic load_block(input logic [NCBPS-1:0] orig);
    logic [NCBPS-1:0] chan;
    chan = '0;
    for (int k = 0; k < NCBPS; k++) chan[fwd(k)] = orig[k];
    for (int j = 0; j < NCBPS; j++) in_q.push_back(chan[j]);
    for (int k = 0; k < NCBPS; k++) exp_q.push_back(orig[k]);
  endtask

  function automatic logic [NCBPS-1:0] rand_block();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic clear_queues();
    in_q.delete();
    exp_q.delete();
    out_d.delete();
    out_i.delete();
    out_cyc.delete();
  endtask

  task automatic do_reset();
    resetN      = 1'b0;
    valid_demod = 1'b0;
    data_in     = 1'b0;
    ready_fec   = 1'b0;
    @(posedge clk);
    #1;
    resetN = 1'b1;
    clear_queues();
  endtask

  // mode 0: ready_fec=1, mode 1: random 50%, mode 2: ready_fec=0
  task automatic run(input int mode, input int n_out, input int max_cyc);
    bit               prev_hold;
    logic             pd;
    logic [IDX_W-1:0] pidx;
    prev_hold    = 1'b0;
    pd           = 1'b0;
    pidx         = '0;
    acc_cnt      = 0;
    rdy_low_cnt  = 0;
    unstable_cnt = 0;
    first_wr_cyc = -1;
    for (int c = 0; c < max_cyc && out_d.size() < n_out; c++) begin
      valid_demod = (in_q.size() > 0);
      data_in     = (in_q.size() > 0) ? in_q[0] : 1'b0;
      ready_fec   = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (prev_hold && (data_out !== pd || data_out_index !== pidx)) unstable_cnt++;
      if (valid_demod && !ready_deinterleaver) rdy_low_cnt++;
      if (valid_deinterleaver && ready_fec) begin
        out_d.push_back(data_out);
        out_i.push_back(int'(data_out_index));
        out_cyc.push_back(c);
      end
      if (valid_demod && ready_deinterleaver) begin
        if (first_wr_cyc < 0) first_wr_cyc = c;
        void'(in_q.pop_front());
        acc_cnt++;
      end
      prev_hold = valid_deinterleaver && !ready_fec;
      pd        = data_out;
      pidx      = data_out_index;
      @(posedge clk);
      #1;
    end
    valid_demod = 1'b0;
    ready_fec   = 1'b0;
  endtask

  task automatic check_out(input string name, input int n);
    int bad;
    bad = 0;
    check({name, "_count"}, out_d.size(), n);
    for (int i = 0; i < out_d.size() && i < exp_q.size(); i++) begin
      if (out_i[i] != i % NCBPS || out_d[i] != exp_q[i]) bad++;
    end
    check({name, "_bad_bits"}, bad, 0);
  endtask

  initial begin
    vec_t vecs[8];
    vecs[0] = '{j: 12,  k: 1};
    vecs[1] = '{j: 1,   k: 16};
    vecs[2] = '{j: 191, k: 191};
    vecs[3] = '{j: 0,   k: 0};
    vecs[4] = '{j: 2,   k: 32};
    vecs[5] = '{j: 13,  k: 17};
    vecs[6] = '{j: 100, k: 72};
    vecs[7] = '{j: 50,  k: 36};

    resetN = 1'b0;
    valid_demod = 1'b0;
    data_in = 1'b0;
    ready_fec = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    check("rst_valid", int'(valid_deinterleaver), 0);
    check("rst_ready", int'(ready_deinterleaver), 1);
    check("rst_data_out", int'(data_out), 0);
    check("rst_index", int'(data_out_index), 0);

    // Single-one blocks with hand-computed destinations
    foreach (vecs[v]) begin
      int ones;
      int pos;
      do_reset();
      check($sformatf("fn_index_j%0d", vecs[v].j), int'(deint_index(IDX_W'(vecs[v].j))), vecs[v].k);
      for (int j = 0; j < NCBPS; j++) in_q.push_back(j == vecs[v].j);
      run(0, NCBPS, 600);
      ones = 0;
      pos  = -1;
      foreach (out_d[i]) if (out_d[i]) begin ones++; pos = i; end
      check($sformatf("one_count_j%0d", vecs[v].j), ones, 1);
      check($sformatf("one_index_j%0d", vecs[v].j), (pos >= 0) ? out_i[pos] : -1, vecs[v].k);
      check($sformatf("one_latency_j%0d", vecs[v].j),
            (pos >= 0) ? out_cyc[pos] - first_wr_cyc : -1, NCBPS + vecs[v].k);
    end

    // Random round trip through the forward interleaver
    do_reset();
    load_block(rand_block());
    run(0, NCBPS, 600);
    check_out("roundtrip", NCBPS);

    // Random backpressure
    do_reset();
    load_block(rand_block());
    run(1, NCBPS, 3000);
    check_out("backpressure", NCBPS);
    check("backpressure_stable", unstable_cnt, 0);

    // Three blocks back-to-back
    do_reset();
    for (int b = 0; b < 3; b++) load_block(rand_block());
    run(0, 3 * NCBPS, 3000);
    check_out("b2b", 3 * NCBPS);
`ifdef DEINT_PINGPONG_EN
    check("b2b_ready_low_cycles", rdy_low_cnt, 0);
    check("b2b_continuous", (out_cyc.size() == 3 * NCBPS) ? out_cyc[3 * NCBPS - 1] - out_cyc[0] : -1,
          3 * NCBPS - 1);
`else
    check("b2b_ready_low_cycles", rdy_low_cnt, 2 * NCBPS);
`endif

    // Stall with the FEC never ready
    do_reset();
    for (int b = 0; b < 3; b++) load_block(rand_block());
    run(2, 1, 700);
`ifdef DEINT_PINGPONG_EN
    check("stall_accepted", acc_cnt, 2 * NCBPS);
`else
    check("stall_accepted", acc_cnt, NCBPS);
`endif
    check("stall_ready", int'(ready_deinterleaver), 0);
    check("stall_valid", int'(valid_deinterleaver), 1);

    // Reset after 100 input bits, then a clean block
    do_reset();
    for (int j = 0; j < 100; j++) in_q.push_back(1'($urandom_range(0, 1)));
    run(0, 1, 150);
    check("mid_accepted", acc_cnt, 100);
    resetN = 1'b0;
    @(posedge clk);
    #1;
    resetN = 1'b1;
    check("mid_rst_valid", int'(valid_deinterleaver), 0);
    check("mid_rst_ready", int'(ready_deinterleaver), 1);
    clear_queues();
    load_block(rand_block());
    run(0, NCBPS, 600);
    check_out("after_mid_rst", NCBPS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
